// File: rtl/sobel_buffer_reader.sv
// Read-side sequencer for the sobel line buffer: walks an address span and streams the words out over valid/ready.
// Define SOBEL_READER_STALL_COUNT_EN to add the stallCycles backpressure counter output.
module sobel_buffer_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  nReset,
  input  logic                  startRead,
  input  logic [ADDR_WIDTH-1:0] startAddress,
  input  logic [ADDR_WIDTH:0]   wordCount,
  output logic [ADDR_WIDTH-1:0] bufferAddress,
  input  logic [DATA_WIDTH-1:0] bufferData,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  outLast,
  output logic                  busy,
  output logic                  done
`ifdef SOBEL_READER_STALL_COUNT_EN
  ,
  output logic [15:0]           stallCycles
`endif
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  in_flight_q, in_flight_d;
  logic                  in_flight_last_q, in_flight_last_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_d [2];
  logic [1:0]            fifo_last_q, fifo_last_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            fifo_count_q, fifo_count_d;

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [2:0]            credit;

  assign outValid      = (fifo_count_q != 2'd0);
  assign outData       = fifo_data_q[rd_ptr_q];
  assign outLast       = outValid & fifo_last_q[rd_ptr_q];
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign bufferAddress = addr_q;

  assign pop  = outValid & outReady;
  assign push = in_flight_q;

  // Occupancy the FIFO will have once the pending capture and this cycle's pop settle;
  // a new read may only issue if its word is guaranteed a free slot.
  assign credit = {1'b0, fifo_count_q} + {2'b00, in_flight_q} - {2'b00, pop};
  assign issue  = (state_q == READ) && (remaining_q != '0) && (credit < 3'd2);

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = bufferData;
      fifo_last_d[wr_ptr_q] = in_flight_last_q;
    end
    wr_ptr_d     = wr_ptr_q ^ push;
    rd_ptr_d     = rd_ptr_q ^ pop;
    fifo_count_d = fifo_count_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    remaining_d      = remaining_q;
    in_flight_d      = issue;
    in_flight_last_d = issue && (remaining_q == (ADDR_WIDTH+1)'(1));
    done_d           = 1'b0;
    case (state_q)
      IDLE: begin
        if (startRead) begin
          if (wordCount != '0) begin
            addr_d      = startAddress;
            remaining_d = wordCount;
            state_d     = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The last word leaving the FIFO this cycle ends the span.
        if (!in_flight_q && (fifo_count_d == 2'd0)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      remaining_q      <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
      done_q           <= 1'b0;
      fifo_data_q[0]   <= '0;
      fifo_data_q[1]   <= '0;
      fifo_last_q      <= '0;
      wr_ptr_q         <= 1'b0;
      rd_ptr_q         <= 1'b0;
      fifo_count_q     <= '0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      remaining_q      <= remaining_d;
      in_flight_q      <= in_flight_d;
      in_flight_last_q <= in_flight_last_d;
      done_q           <= done_d;
      fifo_data_q      <= fifo_data_d;
      fifo_last_q      <= fifo_last_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      fifo_count_q     <= fifo_count_d;
    end
  end

`ifdef SOBEL_READER_STALL_COUNT_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((state_q == IDLE) && startRead) begin
      stall_cycles_d = '0;
    end else if (busy && outValid && !outReady && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stallCycles = stall_cycles_q;
`endif

  fifo_no_overflow: assert property (@(posedge clock) disable iff (!nReset)
    !(push && !pop && (fifo_count_q == 2'd2)));

endmodule

// File: tb/tb_sobel_buffer_reader.sv
// Bench for sobel_buffer_reader: a registered-read buffer model feeds the DUT and every
// streamed span is compared against words looked up directly from the buffer contents.
module tb_sobel_buffer_reader;

  logic        clock = 1'b0;
  logic        nReset = 1'b0;
  logic        startRead = 1'b0;
  logic [7:0]  startAddress = '0;
  logic [8:0]  wordCount = '0;
  logic [7:0]  bufferAddress;
  logic [15:0] bufferData = '0;
  logic [15:0] outData;
  logic        outValid;
  logic        outReady = 1'b0;
  logic        outLast;
  logic        busy;
  logic        done;
`ifdef SOBEL_READER_STALL_COUNT_EN
  logic [15:0] stallCycles;
`endif

  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;

  logic [15:0] obs_data[$];
  bit          obs_last[$];
  int          first_valid, last_xfer, done_cycle, done_count, stalls, stable_err, timed_out;
  logic        done_after, busy_after;

  sobel_buffer_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clock        (clock),
    .nReset       (nReset),
    .startRead    (startRead),
    .startAddress (startAddress),
    .wordCount    (wordCount),
    .bufferAddress(bufferAddress),
    .bufferData   (bufferData),
    .outData      (outData),
    .outValid     (outValid),
    .outReady     (outReady),
    .outLast      (outLast),
    .busy         (busy),
    .done         (done)
`ifdef SOBEL_READER_STALL_COUNT_EN
    ,
    .stallCycles  (stallCycles)
`endif
  );

  always #5 clock = ~clock;

  // Line buffer read port: one-cycle registered read.
  always @(posedge clock) bufferData <= mem[bufferAddress];

  function automatic logic [15:0] model_word(input logic [7:0] a, input int k);
    logic [7:0] idx;
    idx = a + 8'(k);
    return mem[idx];
  endfunction

  task automatic pulse_start(input logic [7:0] a, input logic [8:0] n);
    @(negedge clock);
    startRead = 1'b1;
    startAddress = a;
    wordCount = n;
    @(negedge clock);
    startRead = 1'b0;
  endtask

  // Records the stream seen after a start; cycle 1 is the first cycle after the start edge.
  task automatic capture(input int ready_pct, input int max_cycles, input int inject_cycle);
    logic [15:0] held;
    bit stalled;
    obs_data.delete();
    obs_last.delete();
    first_valid = 0; last_xfer = 0; done_cycle = 0; done_count = 0;
    stalls = 0; stable_err = 0; timed_out = 1;
    stalled = 0; held = '0;
    for (int c = 1; c <= max_cycles; c++) begin
      if (c > 1) @(negedge clock);
      startRead = (c == inject_cycle);
      if (c == inject_cycle) begin
        startAddress = 8'h80;
        wordCount = 9'd3;
      end
      outReady = ($urandom_range(99) < ready_pct);
      #1;
      if (outValid) begin
        if (first_valid == 0) first_valid = c;
        if (stalled && outData !== held) stable_err++;
        if (outReady) begin
          obs_data.push_back(outData);
          obs_last.push_back(outLast);
          last_xfer = c;
          stalled = 0;
        end else begin
          stalls++;
          stalled = 1;
          held = outData;
        end
      end
      if (done === 1'b1) begin
        done_count++;
        done_cycle = c;
        timed_out = 0;
        break;
      end
    end
    @(negedge clock);
    startRead = 1'b0;
    outReady = 1'b1;
    #1;
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    #1;
    checks++;
    if (outValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bufferAddress !== 8'h00 || outLast !== 1'b0) begin
      errors++;
      $display("FAIL reset_assert: valid=%b busy=%b done=%b addr=%h last=%b, required 0 0 0 00 0",
               outValid, busy, done, bufferAddress, outLast);
    end
    repeat (3) @(negedge clock);
    nReset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      #1;
      checks++;
      if (outValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bufferAddress !== 8'h00 || outLast !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: valid=%b busy=%b done=%b addr=%h last=%b, required 0 0 0 00 0",
                 c, outValid, busy, done, bufferAddress, outLast);
      end
    end
  endtask

  task automatic test_basic_span();
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    pulse_start(8'h10, 9'd4);
    capture(100, 50, 0);
    checks++;
    if (timed_out != 0) begin errors++; $display("FAIL basic_timeout: no done within budget"); end
    checks++;
    if (first_valid != 3) begin errors++; $display("FAIL basic_latency: first valid at cycle %0d, required 3", first_valid); end
    checks++;
    if (obs_data.size() != 4) begin errors++; $display("FAIL basic_count: got %0d words, required 4", obs_data.size()); end
    for (int k = 0; k < 4 && k < obs_data.size(); k++) begin
      checks++;
      if (obs_data[k] !== 16'(48 + 3 * k) || obs_last[k] != (k == 3)) begin
        errors++;
        $display("FAIL basic_word %0d: data=%h last=%b, required %h %b", k, obs_data[k], obs_last[k], 16'(48 + 3 * k), k == 3);
      end
    end
    checks++;
    if (last_xfer != first_valid + 3) begin errors++; $display("FAIL basic_throughput: last at %0d, required %0d", last_xfer, first_valid + 3); end
    checks++;
    if (done_cycle != last_xfer + 1) begin errors++; $display("FAIL basic_done_time: done at %0d, required %0d", done_cycle, last_xfer + 1); end
    checks++;
    if (done_after !== 1'b0 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL basic_after_done: done=%b busy=%b, required 0 0", done_after, busy_after);
    end
  endtask

  task automatic test_wrap();
    pulse_start(8'hFE, 9'd4);
    capture(100, 50, 0);
    checks++;
    if (timed_out != 0 || obs_data.size() != 4) begin
      errors++;
      $display("FAIL wrap_count: timeout=%0d words=%0d, required 0 4", timed_out, obs_data.size());
    end
    for (int k = 0; k < obs_data.size(); k++) begin
      checks++;
      if (obs_data[k] !== model_word(8'hFE, k) || obs_last[k] != (k == 3)) begin
        errors++;
        $display("FAIL wrap_word %0d: data=%h last=%b, required %h %b", k, obs_data[k], obs_last[k], model_word(8'hFE, k), k == 3);
      end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    pulse_start(8'h00, 9'd256);
    capture(50, 3000, 0);
    checks++;
    if (timed_out != 0 || obs_data.size() != 256) begin
      errors++;
      $display("FAIL bp_count: timeout=%0d words=%0d, required 0 256", timed_out, obs_data.size());
    end
    bad = 0;
    for (int k = 0; k < obs_data.size(); k++) begin
      if (obs_data[k] !== model_word(8'h00, k) || obs_last[k] != (k == 255)) begin
        if (bad < 4) $display("FAIL bp_word %0d: data=%h last=%b, required %h %b", k, obs_data[k], obs_last[k], model_word(8'h00, k), k == 255);
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_stream: %0d wrong words, required 0", bad); end
    checks++;
    if (stable_err != 0) begin errors++; $display("FAIL bp_stable: %0d data changes while stalled, required 0", stable_err); end
    checks++;
    if (done_cycle != last_xfer + 1) begin errors++; $display("FAIL bp_done_time: done at %0d, required %0d", done_cycle, last_xfer + 1); end
`ifdef SOBEL_READER_STALL_COUNT_EN
    checks++;
    if (stallCycles !== 16'(stalls)) begin errors++; $display("FAIL bp_stall_count: stallCycles=%0d, required %0d", stallCycles, stalls); end
`endif
  endtask

  task automatic test_random_spans();
    logic [7:0] a;
    logic [8:0] n;
    int pct, bad;
    for (int r = 0; r < 4; r++) begin
      a = 8'($urandom_range(255));
      n = 9'($urandom_range(256, 1));
      pct = $urandom_range(100, 30);
      pulse_start(a, n);
      capture(pct, 3000, 0);
      bad = (obs_data.size() != int'(n)) ? 1 : 0;
      for (int k = 0; k < obs_data.size(); k++) begin
        if (obs_data[k] !== model_word(a, k) || obs_last[k] != (k == int'(n) - 1)) bad++;
      end
      checks++;
      if (timed_out != 0 || bad != 0 || stable_err != 0 || done_cycle != last_xfer + 1) begin
        errors++;
        $display("FAIL random_span %0d (a=%h n=%0d): timeout=%0d words=%0d bad=%0d unstable=%0d done=%0d last=%0d, required 0 %0d 0 0 last+1",
                 r, a, n, timed_out, obs_data.size(), bad, stable_err, done_cycle, last_xfer, n);
      end
`ifdef SOBEL_READER_STALL_COUNT_EN
      checks++;
      if (stallCycles !== 16'(stalls)) begin errors++; $display("FAIL random_stall_count %0d: stallCycles=%0d, required %0d", r, stallCycles, stalls); end
`endif
    end
  endtask

  task automatic test_zero_and_busy();
    bit quiet;
    pulse_start(8'h33, 9'd0);
    capture(100, 6, 0);
    checks++;
    if (done_cycle != 1 || first_valid != 0 || obs_data.size() != 0) begin
      errors++;
      $display("FAIL zero_count: done at %0d first_valid=%0d words=%0d, required 1 0 0", done_cycle, first_valid, obs_data.size());
    end
    checks++;
    if (done_after !== 1'b0 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL zero_count_after: done=%b busy=%b, required 0 0", done_after, busy_after);
    end
    pulse_start(8'h20, 9'd6);
    capture(100, 60, 2);
    checks++;
    if (timed_out != 0 || obs_data.size() != 6) begin
      errors++;
      $display("FAIL busy_start_count: timeout=%0d words=%0d, required 0 6", timed_out, obs_data.size());
    end
    for (int k = 0; k < obs_data.size(); k++) begin
      checks++;
      if (obs_data[k] !== model_word(8'h20, k) || obs_last[k] != (k == 5)) begin
        errors++;
        $display("FAIL busy_start_word %0d: data=%h last=%b, required %h %b", k, obs_data[k], obs_last[k], model_word(8'h20, k), k == 5);
      end
    end
    quiet = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      #1;
      if (busy !== 1'b0 || outValid !== 1'b0 || done !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL busy_start_ignored: activity after span, required idle"); end
  endtask

  task automatic test_reset_mid();
    int xfers;
    bit quiet;
    pulse_start(8'h00, 9'd20);
    outReady = 1'b1;
    xfers = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge clock);
      #1;
      if (outValid === 1'b1 && outReady) xfers++;
      if (xfers == 5) break;
    end
    checks++;
    if (xfers != 5) begin errors++; $display("FAIL mid_reset_setup: %0d transfers, required 5", xfers); end
    @(posedge clock);
    #2;
    nReset = 1'b0;
    #1;
    checks++;
    if (outValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bufferAddress !== 8'h00 || outLast !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: valid=%b busy=%b done=%b addr=%h last=%b, required 0 0 0 00 0",
               outValid, busy, done, bufferAddress, outLast);
    end
    @(negedge clock);
    nReset = 1'b1;
    quiet = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      #1;
      if (done !== 1'b0 || outValid !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL mid_reset_no_done: activity after abort, required idle"); end
    pulse_start(8'h40, 9'd2);
    capture(100, 40, 0);
    checks++;
    if (timed_out != 0 || obs_data.size() != 2 || done_cycle != last_xfer + 1) begin
      errors++;
      $display("FAIL mid_reset_restart: timeout=%0d words=%0d done=%0d last=%0d, required 0 2 last+1", timed_out, obs_data.size(), done_cycle, last_xfer);
    end
    for (int k = 0; k < obs_data.size(); k++) begin
      checks++;
      if (obs_data[k] !== model_word(8'h40, k) || obs_last[k] != (k == 1)) begin
        errors++;
        $display("FAIL mid_reset_word %0d: data=%h last=%b, required %h %b", k, obs_data[k], obs_last[k], model_word(8'h40, k), k == 1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_basic_span();
    test_wrap();
    test_backpressure();
    test_random_spans();
    test_zero_and_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sobel_buffer_reader.md
Name: sobel_buffer_reader

Overview:
- Read-side sequencer for the 256 x 16-bit sobel line buffer.
- On a start request, walks a span of buffer addresses and absorbs the buffer's 1-cycle registered read latency.
- Delivers the words as a valid/ready stream to the downstream sobel/DMA consumer, with full throughput and lossless backpressure.
- Lives entirely in the consumer clock domain. The writer side of the buffer is outside this block.

Parameters:
- ADDR_WIDTH, 8, buffer address width; buffer depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 16, buffer word width.

Ports:
- clock  in  1  consumer clock; also drives the buffer read port.
- nReset  in  1  asynchronous, active-low reset.
- startRead  in  1  one-cycle request; sampled only when busy=0.
- startAddress  in  ADDR_WIDTH  first buffer address of the span.
- wordCount  in  ADDR_WIDTH+1  number of words; valid range 0..2^ADDR_WIDTH.
- bufferAddress  out  ADDR_WIDTH  read address to buffer (addressOut).
- bufferData  in  DATA_WIDTH  registered buffer output (dataOut), valid 1 cycle after the address.
- outData  out  DATA_WIDTH  stream data.
- outValid  out  1  stream valid.
- outReady  in  1  stream ready; a word transfers on outValid & outReady at a rising edge.
- outLast  out  1  high with the final word of the span.
- busy  out  1  span in progress.
- done  out  1  one-cycle pulse after the last word transfers.

Behaviour:
- Reset (nReset=0, takes effect asynchronously): state IDLE, bufferAddress=0, outValid=0, outLast=0, busy=0, done=0, FIFO emptied, all counters 0.
- A reset mid-span aborts the span. No done pulse is generated; words not yet transferred are discarded.
- States:
  - IDLE: busy=0. On startRead with wordCount>0: latch startAddress into the address register and wordCount into the remaining counter, then go to READ. On startRead with wordCount=0: pulse done the next cycle and stay in IDLE.
  - READ: busy=1. A read issues in every cycle where issue = (remaining>0) & (fifoCount + inFlight - pop < 2), with pop = outValid & outReady. On each issue: address increments mod 2^ADDR_WIDTH (0xFF wraps to 0x00), remaining decrements, inFlight is set for the next cycle. When remaining reaches 0, go to DRAIN.
  - DRAIN: busy=1. No new reads. When fifoCount=0, inFlight=0 and the last word has transferred, go to DONE.
  - DONE: busy=1 and done=1 for exactly one cycle, then IDLE.
- bufferAddress is driven directly from the address register. The returned word is captured into the FIFO the cycle after its issue (inFlight=1).
- FIFO is 2 entries deep and registered. outData/outValid come from its head.
- outLast is tagged on the entry whose issue decremented remaining to 0.
- Latency: startRead sampled at edge E. First address is presented after E, bufferData is valid after E+1, FIFO is written at E+2 so outValid=1 after E+2. With outReady held at 1, one word transfers per cycle.
- Backpressure:
  - Data must be stable while outValid=1 & outReady=0.
  - The credit rule guarantees the FIFO never overflows. An overflow condition is a design error; flag it with an assertion in simulation.
  - Simultaneous push and pop in one cycle leaves fifoCount unchanged.
- wordCount = 2^ADDR_WIDTH reads the whole buffer once, ending at startAddress-1 mod depth.
- startRead while busy=1 is ignored.

Optional Feature:
- Macro SOBEL_READER_STALL_COUNT_EN.
- When defined, add output stallCycles (16 bits):
  - Cleared when a span starts.
  - Increments, saturating at 0xFFFF, each busy cycle with outValid=1 & outReady=0.
  - Holds its value after done until the next start.
  - Reset value 0.
- When not defined, the port and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset/idle: nReset low then high, no start -> outValid=0, busy=0, done=0, bufferAddress=0 for 20 cycles.
- Basic span: buffer preloaded with mem[i]=i*3; start(0x10, 4) with outReady=1 -> outValid first high 3 cycles after start. Stream is 0x0030, 0x0033, 0x0036, 0x0039 on consecutive cycles; outLast on 0x0039; done one cycle later.
- Wrap: start(0xFE, 4) -> addresses 0xFE, 0xFF, 0x00, 0x01 in order; data matches mem at those addresses.
- Backpressure: start(0, 256) with outReady random 50% -> all 256 words in order, no loss or duplication. outData stays stable while stalled. With SOBEL_READER_STALL_COUNT_EN, stallCycles equals the count of observed stall cycles.
- Zero count / busy start: start(x, 0) -> done pulse the next cycle with no outValid. A second startRead during an active span is ignored, and the original span completes intact.
- Reset mid-span: assert nReset low after 5 of 20 words -> outputs return to reset values immediately and no done pulse follows. A new start(0x40, 2) then completes normally.
